assoc_data_cache: RTL and testbench
===================================

// Module: assoc_data_cache
// PURPOSE
//  Parametrised N-set, 1- or 2-way set-associative write-back/write-allocate data cache.
//  Sits between the CPU load/store path and the block-wide data memory.
//  Adds the following over the direct-mapped cache:
//  - a second way with LRU replacement
//  - generic widths and depths
//  - a fill handshake that only writes the arrays on clock edges
//  - saturating hit/miss counters
// PARAMETERS
//  ADDR_W       8   CPU byte-address width
//  DATA_W       8   CPU word width (bits)
//  BLOCK_WORDS  4   words per block, power of 2 (>=2); OFF_W=log2(BLOCK_WORDS)
//  SETS         8   number of sets, power of 2; IDX_W=log2(SETS)
//  WAYS         2   associativity, 1 or 2
//  CNT_W        16  width of the performance counters
//  Derived widths:
//  - TAG_W = ADDR_W-IDX_W-OFF_W
//  - BLK_W = DATA_W*BLOCK_WORDS
//  - MADDR_W = ADDR_W-OFF_W
// PORTS
//  clock          in   1        rising-edge clock
//  reset          in   1        asynchronous, active-low reset (0 = reset)
//  read           in   1        CPU load request, held until busywait low
//  write          in   1        CPU store request, held until busywait low
//  address        in   ADDR_W   CPU byte address {tag,index,offset}
//  cpu_writedata  in   DATA_W   store data
//  cpu_readdata   out  DATA_W   load data, valid when read=1 and busywait=0
//  busywait       out  1        stall CPU
//  mem_read       out  1        block read request
//  mem_write      out  1        block write request
//  mem_address    out  MADDR_W  block address {tag,index}
//  mem_writedata  out  BLK_W    victim block
//  mem_readdata   in   BLK_W    fill block
//  mem_busywait   in   1        memory busy; low = transfer complete this cycle
//  hit_count      out  CNT_W    saturating count of hit accesses
//  miss_count     out  CNT_W    saturating count of miss accesses
// BEHAVIOUR
//  Reset (async, reset=0):
//  - state=IDLE; all valid, dirty and LRU bits cleared; counters cleared
//  - mem_read, mem_write and busywait forced to 0
//  - any memory transaction in flight is abandoned; its data is never written to the arrays
//  Request rules:
//  - req = read|write; read and write both high is treated as a write
//  - hit = some way w has valid[w][idx] and tag[w][idx]==tag
//  - busywait = req & ~(state==IDLE & hit), combinational
//  Latency:
//  - hit: 0 stall cycles
//  - clean miss: 1 + fill cycles
//  - dirty miss: writeback + 1 + fill cycles
//  Read hit: cpu_readdata = word[offset] of the hit way, combinational; 0 when no hit.
//  Write hit: at posedge, word[offset] of the hit way <= cpu_writedata; dirty <= 1.
//  Any IDLE hit at posedge:
//  - LRU[idx] <= other way (WAYS=2)
//  - hit_count++ (saturates at all-ones)
//  FSM states:
//  - IDLE: on req & ~hit, choose victim, miss_count++ and latch victim way.
//    Victim = first invalid way (way0 first), else LRU[idx].
//    Go to WRITEBACK if the victim is valid & dirty, else ALLOCATE.
//  - WRITEBACK:
//    - mem_write=1, mem_address={victim tag,idx}, mem_writedata=victim block
//    - at a posedge with mem_busywait=0: dirty <= 0, go to ALLOCATE
//  - ALLOCATE:
//    - mem_read=1, mem_address={tag,idx}
//    - at a posedge with mem_busywait=0: victim block <= mem_readdata, tag <= tag, valid <= 1, dirty <= 0, go to IDLE
//    - the request then hits in IDLE; a store merges its data at that edge
//  - mem_read and mem_write are never high together; both are 0 in IDLE.
//  - Memory-side outputs are 0 when inactive.
//  - The address and request must stay stable while busywait=1; changing them is a CPU protocol violation with undefined result.
//  - WAYS=1: the LRU logic is removed and way0 is always the victim.
//  - A miss is counted once per request, not once per stall cycle.
// TESTING
//  1. Reset, then read 0x00 (mem block=0x44332211): one miss, 1 ALLOCATE, then cpu_readdata=0x11; miss_count=1, hit_count=1.
//  2. Write 0xAA to 0x01, read 0x01 -> 0 stall cycles, reads 0xAA, dirty set; mem_write never asserted.
//  3. Defaults: fill 0x00, write to it, access 0x20, access 0x40 (all set 0).
//     -> The 0x40 miss evicts way holding 0x00 (LRU).
//     -> WRITEBACK mem_address=0x00 with 0x443322AA, then ALLOCATE 0x10.
//  4. Hit on 0x00 after filling ways with 0x00 and 0x20, then miss 0x40 -> 0x20 way replaced with no writeback; 0x00 still hits.
//  5. Assert reset=0 mid-ALLOCATE while mem_busywait=1.
//     -> mem_read=0 and busywait=0 immediately.
//     -> After release, the next read of the same address misses again.
//  6. Drive 2^CNT_W hits -> hit_count holds all-ones and never wraps to 0.

Source files
------------

// File: rtl/assoc_data_cache.sv
// rtl/assoc_data_cache.sv - 1/2-way set-associative write-back, write-allocate data cache
module assoc_data_cache #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int CNT_W       = 16,
  localparam int OFF_W      = $clog2(BLOCK_WORDS),
  localparam int IDX_W      = $clog2(SETS),
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
  localparam int BLK_W      = DATA_W * BLOCK_WORDS,
  localparam int MADDR_W    = ADDR_W - OFF_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  cpu_writedata,
  output logic [DATA_W-1:0]  cpu_readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [MADDR_W-1:0] mem_address,
  output logic [BLK_W-1:0]   mem_writedata,
  input  logic [BLK_W-1:0]   mem_readdata,
  input  logic               mem_busywait,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t            state_q;
  logic              victim_q;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [BLK_W-1:0]  data_q  [WAYS][SETS];

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;

  logic              req;
  logic              hit;
  logic              hit_way;
  logic              idle_hit;
  logic              new_victim;
  logic              victim_dirty;
  logic              fill_done;

  assign {tag, idx, off} = address;
  assign req       = read | write;
  assign idle_hit  = (state_q == S_IDLE) & req & hit;
  assign fill_done = (state_q == S_ALLOCATE) & ~mem_busywait;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Load data comes straight out of the hit way; zero when nothing matches
  always_comb begin
    cpu_readdata = '0;
    if (hit) cpu_readdata = data_q[hit_way][idx][off*DATA_W +: DATA_W];
  end

  // Victim: first invalid way (way0 first), otherwise the least recently used way
  always_comb begin
    new_victim = lru_q[idx];
    if (WAYS == 1)                    new_victim = 1'b0;
    else if (!valid_q[0][idx])        new_victim = 1'b0;
    else if (!valid_q[WAYS-1][idx])   new_victim = 1'b1;
    victim_dirty = valid_q[new_victim][idx] & dirty_q[new_victim][idx];
  end

  // Reset gating keeps the CPU free while the cache is held in reset
  assign busywait = reset & req & ~((state_q == S_IDLE) & hit);

  // Memory side is a pure decode of the state flop, so it is glitch-free and idle in IDLE
  always_comb begin
    mem_write     = (state_q == S_WRITEBACK);
    mem_read      = (state_q == S_ALLOCATE);
    mem_address   = '0;
    mem_writedata = '0;
    if (state_q == S_WRITEBACK) begin
      mem_address   = {tag_q[victim_q][idx], idx};
      mem_writedata = data_q[victim_q][idx];
    end else if (state_q == S_ALLOCATE) begin
      mem_address   = {tag, idx};
    end
  end

  // Controller: miss handling FSM, status bits, LRU and performance counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      victim_q   <= 1'b0;
      lru_q      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && hit) begin
            if (write) dirty_q[hit_way][idx] <= 1'b1;
            if (WAYS == 2) lru_q[idx] <= ~hit_way;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else if (req) begin
            // Counted only here, so a stalled request is one miss however long it waits
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            victim_q <= new_victim;
            state_q  <= victim_dirty ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (!mem_busywait) begin
            dirty_q[victim_q][idx] <= 1'b0;
            state_q                <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (!mem_busywait) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
            state_q                <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays change only on clock edges: store hits and completed fills
  always_ff @(posedge clock) begin
    if (reset && idle_hit && write)
      data_q[hit_way][idx][off*DATA_W +: DATA_W] <= cpu_writedata;
    if (reset && fill_done) begin
      data_q[victim_q][idx] <= mem_readdata;
      tag_q[victim_q][idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_assoc_data_cache.sv
// tb/tb_assoc_data_cache.sv - directed self-checking bench for assoc_data_cache
module tb_assoc_data_cache;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = '0;
  logic [7:0]  cpu_writedata = '0;
  logic [7:0]  cpu_readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [64];
  int          mcnt = 0;
  int          wb_count = 0;
  int          rd_count = 0;
  int          mw_cycles = 0;
  int          both_cycles = 0;
  logic [5:0]  last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;
  logic [5:0]  last_rd_addr = '0;

  assoc_data_cache dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  always #5 clock = ~clock;

  // Block memory: busy for LAT cycles, completes on the next; contents reloaded during reset
  assign mem_busywait = (mem_read | mem_write) && (mcnt != LAT);
  assign mem_readdata = mem_read ? mem[mem_address] : 32'h0;

  always @(posedge clock) begin
    if (!reset) begin
      mcnt     <= 0;
      wb_count <= 0;
      rd_count <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h44332211 + 32'(i) * 32'h01010101;
    end else if (mem_read | mem_write) begin
      if (mcnt == LAT) begin
        mcnt <= 0;
        if (mem_write) begin
          mem[mem_address] <= mem_writedata;
          wb_count         <= wb_count + 1;
          last_wb_addr     <= mem_address;
          last_wb_data     <= mem_writedata;
        end else begin
          rd_count     <= rd_count + 1;
          last_rd_addr <= mem_address;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      mw_cycles <= 0;
    end else begin
      if (mem_write) mw_cycles <= mw_cycles + 1;
      if (mem_write && mem_read) both_cycles <= both_cycles + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; cpu_writedata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // One CPU access; returns stall cycles and the data seen when busywait dropped
  task automatic do_access(input logic is_wr, input logic [7:0] a, input logic [7:0] d,
                           output int stalls, output logic [7:0] rdata);
    stalls = 0;
    read = ~is_wr; write = is_wr; address = a; cpu_writedata = d;
    #1;
    while (busywait && stalls < 200) begin
      @(posedge clock);
      #1;
      stalls++;
    end
    n_vec++;
    if (busywait !== 1'b0) begin
      n_bad++;
      $display("FAIL access_timeout addr=%h busywait=%b required 0", a, busywait);
    end
    rdata = cpu_readdata;
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    repeat (2) @(posedge clock);
    #1;
    n_vec++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL rst_busywait got %b exp 0", busywait); end
    n_vec++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mem_read got %b exp 0", mem_read); end
    n_vec++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
    n_vec++; if (hit_count !== 16'h0) begin n_bad++; $display("FAIL rst_hit_count got %h exp 0", hit_count); end
    n_vec++; if (miss_count !== 16'h0) begin n_bad++; $display("FAIL rst_miss_count got %h exp 0", miss_count); end
    reset = 1'b1;
    #1;
    n_vec++; if (cpu_readdata !== 8'h00) begin n_bad++; $display("FAIL rst_readdata got %h exp 00", cpu_readdata); end
  endtask

  task automatic test_clean_miss();
    int st; logic [7:0] rd;
    do_reset();
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    n_vec++; if (st !== 4) begin n_bad++; $display("FAIL t1_stalls got %0d exp 4", st); end
    n_vec++; if (rd !== 8'h11) begin n_bad++; $display("FAIL t1_rdata got %h exp 11", rd); end
    n_vec++; if (rd_count !== 1) begin n_bad++; $display("FAIL t1_fills got %0d exp 1", rd_count); end
    n_vec++; if (last_rd_addr !== 6'h00) begin n_bad++; $display("FAIL t1_fill_addr got %h exp 00", last_rd_addr); end
    n_vec++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL t1_miss_count got %0d exp 1", miss_count); end
    n_vec++; if (hit_count !== 16'd1) begin n_bad++; $display("FAIL t1_hit_count got %0d exp 1", hit_count); end
  endtask

  task automatic test_back_to_back();
    int st; logic [7:0] rd;
    do_access(1'b1, 8'h01, 8'hAA, st, rd);
    n_vec++; if (st !== 0) begin n_bad++; $display("FAIL t2_wr_stalls got %0d exp 0", st); end
    do_access(1'b0, 8'h01, 8'h00, st, rd);
    n_vec++; if (st !== 0) begin n_bad++; $display("FAIL t2_rd_stalls got %0d exp 0", st); end
    n_vec++; if (rd !== 8'hAA) begin n_bad++; $display("FAIL t2_rdata got %h exp aa", rd); end
    do_access(1'b0, 8'h03, 8'h00, st, rd);
    n_vec++; if (rd !== 8'h44) begin n_bad++; $display("FAIL t2_rdata_off3 got %h exp 44", rd); end
    n_vec++; if (mw_cycles !== 0) begin n_bad++; $display("FAIL t2_mem_write_cycles got %0d exp 0", mw_cycles); end
    n_vec++; if (hit_count !== 16'd4) begin n_bad++; $display("FAIL t2_hit_count got %0d exp 4", hit_count); end
    n_vec++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL t2_miss_count got %0d exp 1", miss_count); end
  endtask

  task automatic test_dirty_evict();
    int st; logic [7:0] rd;
    do_reset();
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    do_access(1'b1, 8'h00, 8'hAA, st, rd);
    do_access(1'b0, 8'h20, 8'h00, st, rd);
    n_vec++; if (rd !== 8'h19) begin n_bad++; $display("FAIL t3_rdata_20 got %h exp 19", rd); end
    do_access(1'b0, 8'h40, 8'h00, st, rd);
    n_vec++; if (st !== 7) begin n_bad++; $display("FAIL t3_dirty_stalls got %0d exp 7", st); end
    n_vec++; if (rd !== 8'h21) begin n_bad++; $display("FAIL t3_rdata_40 got %h exp 21", rd); end
    n_vec++; if (wb_count !== 1) begin n_bad++; $display("FAIL t3_writebacks got %0d exp 1", wb_count); end
    n_vec++; if (last_wb_addr !== 6'h00) begin n_bad++; $display("FAIL t3_wb_addr got %h exp 00", last_wb_addr); end
    n_vec++; if (last_wb_data !== 32'h443322AA) begin n_bad++; $display("FAIL t3_wb_data got %h exp 443322aa", last_wb_data); end
    n_vec++; if (last_rd_addr !== 6'h10) begin n_bad++; $display("FAIL t3_fill_addr got %h exp 10", last_rd_addr); end
    n_vec++; if (mw_cycles !== 3) begin n_bad++; $display("FAIL t3_mem_write_cycles got %0d exp 3", mw_cycles); end
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    n_vec++; if (st !== 4) begin n_bad++; $display("FAIL t3_refetch_stalls got %0d exp 4", st); end
    n_vec++; if (rd !== 8'hAA) begin n_bad++; $display("FAIL t3_refetch_rdata got %h exp aa", rd); end
    n_vec++; if (miss_count !== 16'd4) begin n_bad++; $display("FAIL t3_miss_count got %0d exp 4", miss_count); end
  endtask

  task automatic test_lru();
    int st; logic [7:0] rd;
    do_reset();
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    do_access(1'b0, 8'h20, 8'h00, st, rd);
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    n_vec++; if (st !== 0) begin n_bad++; $display("FAIL t4_hit_stalls got %0d exp 0", st); end
    do_access(1'b0, 8'h40, 8'h00, st, rd);
    n_vec++; if (st !== 4) begin n_bad++; $display("FAIL t4_clean_stalls got %0d exp 4", st); end
    n_vec++; if (wb_count !== 0) begin n_bad++; $display("FAIL t4_writebacks got %0d exp 0", wb_count); end
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    n_vec++; if (st !== 0) begin n_bad++; $display("FAIL t4_keep_stalls got %0d exp 0", st); end
    n_vec++; if (rd !== 8'h11) begin n_bad++; $display("FAIL t4_keep_rdata got %h exp 11", rd); end
    do_access(1'b0, 8'h20, 8'h00, st, rd);
    n_vec++; if (st !== 4) begin n_bad++; $display("FAIL t4_evicted_stalls got %0d exp 4", st); end
    n_vec++; if (mw_cycles !== 0) begin n_bad++; $display("FAIL t4_mem_write_cycles got %0d exp 0", mw_cycles); end
  endtask

  task automatic test_reset_mid_fill();
    int st; logic [7:0] rd;
    do_reset();
    read = 1'b1; address = 8'h00;
    @(posedge clock);
    #1;
    n_vec++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL t5_fill_started got %b exp 1", mem_read); end
    n_vec++; if (mem_busywait !== 1'b1) begin n_bad++; $display("FAIL t5_mem_busy got %b exp 1", mem_busywait); end
    reset = 1'b0;
    #1;
    n_vec++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL t5_abort_mem_read got %b exp 0", mem_read); end
    n_vec++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL t5_abort_busywait got %b exp 0", busywait); end
    read = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    n_vec++; if (st !== 4) begin n_bad++; $display("FAIL t5_remiss_stalls got %0d exp 4", st); end
    n_vec++; if (rd !== 8'h11) begin n_bad++; $display("FAIL t5_rdata got %h exp 11", rd); end
    n_vec++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL t5_miss_count got %0d exp 1", miss_count); end
  endtask

  task automatic test_hit_saturate();
    int st; logic [7:0] rd;
    do_reset();
    do_access(1'b0, 8'h00, 8'h00, st, rd);
    read = 1'b1; address = 8'h00;
    repeat (65533) @(posedge clock);
    #1;
    n_vec++; if (hit_count !== 16'hFFFE) begin n_bad++; $display("FAIL t6_pre_sat got %h exp fffe", hit_count); end
    @(posedge clock);
    #1;
    n_vec++; if (hit_count !== 16'hFFFF) begin n_bad++; $display("FAIL t6_sat got %h exp ffff", hit_count); end
    repeat (5) @(posedge clock);
    #1;
    n_vec++; if (hit_count !== 16'hFFFF) begin n_bad++; $display("FAIL t6_no_wrap got %h exp ffff", hit_count); end
    n_vec++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL t6_miss_count got %0d exp 1", miss_count); end
    read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_back_to_back();
    test_dirty_evict();
    test_lru();
    test_reset_mid_fill();
    test_hit_saturate();
    n_vec++;
    if (both_cycles !== 0) begin
      n_bad++;
      $display("FAIL rd_wr_overlap got %0d cycles exp 0", both_cycles);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
